image_bram_reader: RTL and testbench
====================================

Name: image_bram_reader

Overview:
- Scan-out stage directly downstream of the image distributed-memory (dpram/rom) read port.
- On start, walks the read address 0..ADDR_DEPTH-1 and compensates for the memory's fixed read latency.
- Buffers returned pixels in a small FIFO and presents them as a valid/ready pixel stream to the LCD/SPI display driver.
- A credit scheme guarantees no pixel is lost or duplicated under arbitrary backpressure.

Parameters:
- ADDR_DEPTH, 16384, pixels per frame (128x128); memory depth.
- DATA_WIDTH, 16, pixel width (RGB565).
- ADDR_WIDTH, clog2(ADDR_DEPTH), read address width.
- RD_LATENCY, 1, cycles from rd_addr_o/rd_en_o to valid rd_data_i.
  - Legal values 0..2: 0 = unregistered (async) read, 1 = registered output.
- FIFO_DEPTH, 4, output buffer entries.
  - Power of two, >= RD_LATENCY+2; a violation is a $error at elaboration.

Ports:
- clk_i  in  1  single clock for memory read port and stream.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin one frame scan; sampled only in IDLE.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse after the final pixel handshake.
- rd_clk_en_o  out  1  memory read clock enable; equals rd_en_o.
- rd_en_o  out  1  read request this cycle.
- rd_addr_o  out  ADDR_WIDTH  read address.
- rd_data_i  in  DATA_WIDTH  memory read data, RD_LATENCY cycles after request.
- pix_data_o  out  DATA_WIDTH  pixel at FIFO head.
- pix_valid_o  out  1  pixel available.
- pix_ready_i  in  1  consumer accepts; transfer = valid & ready.
- pix_first_o  out  1  qualifies pixel of address 0.
- pix_last_o  out  1  qualifies pixel of address ADDR_DEPTH-1.

Behaviour:
- Reset values: busy_o, done_o, rd_en_o, rd_clk_en_o, pix_valid_o, pix_first_o, pix_last_o = 0; rd_addr_o = 0; pix_data_o = 0.
- Reset clears the FIFO, the in-flight pipeline and the credit counter, and returns the FSM to IDLE.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start_i=1 -> FETCH; rd_addr_o=0 next cycle.
  - FETCH: issue reads; on the cycle issuing address ADDR_DEPTH-1 -> DRAIN.
  - DRAIN: no reads; when the last pixel transfers -> IDLE, with done_o=1 for exactly that next cycle.
- start_i outside IDLE is ignored, including in the done_o cycle. start_i in the done_o cycle is not accepted; it is accepted from the following cycle.
- Credit rule: rd_en_o=1 in FETCH iff (fifo_count + inflight) < FIFO_DEPTH.
  - inflight = reads issued whose data has not yet been written to the FIFO (0..RD_LATENCY+1).
  - Credits return when the FIFO pops. The FIFO can never overflow.
- Address control: rd_addr_o increments only in a cycle with rd_en_o=1; otherwise it holds. No wrap within a frame; resets to 0 when the next frame starts.
- Latency pipeline: a RD_LATENCY-deep shift of {valid, first, last} flags accompanies each request. The flag emerging in the cycle rd_data_i is valid writes {rd_data_i, first, last} into the FIFO at that cycle's clock edge. RD_LATENCY=0 writes in the issue cycle.
- FIFO: first-word-fall-through; pix_data_o/pix_first_o/pix_last_o reflect the head entry.
  - Simultaneous push and pop on a full or empty FIFO is legal; count is unchanged when push and pop coincide.
- Latency: with start_i high in cycle 0 and ready high, rd_en_o is high in cycle 1 and first pix_valid_o is in cycle RD_LATENCY+2.
- Throughput: one pixel per cycle sustained while pix_ready_i=1.
- Stream rule: pix_valid_o never deasserts without a transfer, and the data/flags stay stable while valid & !ready.
- Frame end: done_o follows the transfer of the pix_last_o pixel by one cycle. busy_o falls in the same cycle that done_o is high.

Test Plan:
- Full frame, free-running: ADDR_DEPTH=16, RD_LATENCY=1, FIFO_DEPTH=4, mem[i]=16'hA500+i, ready=1, start in cycle 0.
  - rd_en_o cycles 1-16.
  - pix_valid_o cycles 3-18 with data A500..A50F.
  - first on A500, last on A50F, done_o in cycle 19 only.
- Stall: ready=0 throughout.
  - Exactly 4 reads issued (addr 0-3), then rd_en_o=0 with rd_addr_o held at 4.
  - Releasing ready resumes reads at 4; all 16 pixels delivered, in order, with no duplicates.
- Random backpressure: 50% ready over 10 frames at RD_LATENCY = 0, 1 and 2.
  - Scoreboard matches mem[] order.
  - FIFO count never exceeds FIFO_DEPTH; data is stable while stalled.
- Start while busy: pulse start_i at cycles 5 and 10 of a frame.
  - Ignored: exactly 16 pixels and one done_o.
  - A start in the cycle after done_o begins a new frame at addr 0.
- Reset mid-frame: rst_i high in cycle 8 for 1 cycle.
  - All outputs at reset values from cycle 9.
  - No residual pixels; the next start gives a clean frame from A500.
- Parameter check: FIFO_DEPTH=2 with RD_LATENCY=1 triggers the elaboration error.

Source files
------------

// File: rtl/image_bram_reader.sv
// ---------------------------------------------------------------------------
// image_bram_reader
//   Purpose     : scans an image memory read port from address 0 to
//                 ADDR_DEPTH-1 once per start and re-times the returned pixels
//                 into a valid/ready stream for the display driver.
//   Latency     : start_i in cycle 0 -> rd_en_o in cycle 1 -> first
//                 pix_valid_o in cycle RD_LATENCY+2; one pixel per cycle
//                 sustained while pix_ready_i stays high.
//   Backpressure: reads are only issued while the FIFO occupancy plus the
//                 reads still in flight is below FIFO_DEPTH, so a stalled
//                 consumer stops the address walk without losing or
//                 repeating a pixel.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : begin one frame scan (honoured only when idle)
//   busy_o, done_o        : frame in progress / one-cycle end-of-frame pulse
//   rd_clk_en_o, rd_en_o  : memory clock enable and read request (identical)
//   rd_addr_o, rd_data_i  : memory address out, data back RD_LATENCY later
//   pix_data_o            : pixel at FIFO head
//   pix_valid_o           : pixel available
//   pix_ready_i           : consumer accepts (transfer = valid & ready)
//   pix_first_o           : head pixel came from address 0
//   pix_last_o            : head pixel came from address ADDR_DEPTH-1
// ---------------------------------------------------------------------------
module image_bram_reader #(
  parameter int ADDR_DEPTH = 16384,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_clk_en_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic                  pix_first_o,
  output logic                  pix_last_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // -------------------------------------------------------------------------
  if (RD_LATENCY < 0 || RD_LATENCY > 2) begin : g_bad_latency
    $error("image_bram_reader: RD_LATENCY must be 0, 1 or 2");
  end

  // Below RD_LATENCY+2 entries the credit loop cannot cover the read latency
  // and the stream would bubble; non power-of-two depths break pointer wrap.
  if ((FIFO_DEPTH < RD_LATENCY + 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("image_bram_reader: FIFO_DEPTH must be a power of two >= RD_LATENCY+2");
  end

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_done;
  logic [CNT_W-1:0]        r_inflight;
  logic [CNT_W-1:0]        r_count;
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [DATA_WIDTH-1:0]   r_fifo_dat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   r_fifo_first;
  logic [FIFO_DEPTH-1:0]   r_fifo_last;

  logic [SUM_W-1:0]        w_used;
  logic                    w_rd_en;
  logic                    w_req_first;
  logic                    w_req_last;
  logic                    w_push;
  logic                    w_push_first;
  logic                    w_push_last;
  logic                    w_valid;
  logic                    w_pop;
  logic                    w_head_first;
  logic                    w_head_last;

  // -------------------------------------------------------------------------
  // Credit check: every read already issued owns a FIFO slot, whether its
  // data has landed or is still inside the memory pipeline.
  // -------------------------------------------------------------------------
  assign w_used      = SUM_W'(r_count) + SUM_W'(r_inflight);
  assign w_rd_en     = (r_state == S_FETCH) && (w_used < SUM_W'(FIFO_DEPTH));
  assign w_req_first = (r_addr == '0);
  assign w_req_last  = (r_addr == LAST_ADDR);

  // -------------------------------------------------------------------------
  // Read-latency alignment of the {valid, first, last} tags
  // -------------------------------------------------------------------------
  if (RD_LATENCY == 0) begin : g_lat0
    // Asynchronous read: data is already on rd_data_i in the issue cycle.
    assign w_push       = w_rd_en;
    assign w_push_first = w_rd_en & w_req_first;
    assign w_push_last  = w_rd_en & w_req_last;
  end else begin : g_latn
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [RD_LATENCY-1:0] r_pipe_first;
    logic [RD_LATENCY-1:0] r_pipe_last;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_pipe_vld   <= '0;
        r_pipe_first <= '0;
        r_pipe_last  <= '0;
      end else begin
        r_pipe_vld[0]   <= w_rd_en;
        r_pipe_first[0] <= w_rd_en & w_req_first;
        r_pipe_last[0]  <= w_rd_en & w_req_last;
        for (int k = 1; k < RD_LATENCY; k++) begin
          r_pipe_vld[k]   <= r_pipe_vld[k-1];
          r_pipe_first[k] <= r_pipe_first[k-1];
          r_pipe_last[k]  <= r_pipe_last[k-1];
        end
      end
    end

    // The tag leaving the last stage marks the cycle rd_data_i is valid.
    assign w_push       = r_pipe_vld[RD_LATENCY-1];
    assign w_push_first = r_pipe_first[RD_LATENCY-1];
    assign w_push_last  = r_pipe_last[RD_LATENCY-1];
  end

  // Reads issued whose data has not been written into the FIFO yet. With
  // RD_LATENCY=0 issue and write coincide, so this stays at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= '0;
    end else begin
      case ({w_rd_en, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // First-word-fall-through output FIFO
  // -------------------------------------------------------------------------
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid & pix_ready_i;
  assign w_head_first = r_fifo_first[r_rptr];
  assign w_head_last  = r_fifo_last[r_rptr];

  // Storage needs no reset: occupancy is tracked by r_count and the outputs
  // are gated by it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_dat[r_wptr]   <= rd_data_i;
      r_fifo_first[r_wptr] <= w_push_first;
      r_fifo_last[r_wptr]  <= w_push_last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM and address walker
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle is itself IDLE; a start there is deliberately
          // dropped so a frame restart always needs a fresh cycle.
          if (start_i && !r_done) begin
            r_state <= S_FETCH;
            r_addr  <= '0;
          end
        end
        S_FETCH: begin
          if (w_rd_en) begin
            if (w_req_last) begin
              // Address stays at the final value; no wrap inside a frame.
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // The last-tagged pixel can only reach the head after the final
          // read was issued, so it always leaves the FIFO in this state.
          if (w_pop && w_head_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign rd_en_o     = w_rd_en;
  assign rd_clk_en_o = w_rd_en;
  assign rd_addr_o   = r_addr;

  // Head fields are forced to zero when empty so stale RAM never shows.
  assign pix_valid_o = w_valid;
  assign pix_data_o  = w_valid ? r_fifo_dat[r_rptr] : '0;
  assign pix_first_o = w_valid & w_head_first;
  assign pix_last_o  = w_valid & w_head_last;

endmodule

// File: tb/tb_image_bram_reader.sv
// ---------------------------------------------------------------------------
// tb_image_bram_reader
//   Three readers (RD_LATENCY 0, 1, 2) with a 16-pixel frame, FIFO_DEPTH 4,
//   each fed by its own memory model holding mem[i] = 16'hA500 + i.
//   start_i and rst_i are shared; pix_ready_i is per instance.
// ---------------------------------------------------------------------------
module tb_image_bram_reader;

  localparam int AD = 16;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int FD = 4;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NI-1:0] ready;
  logic [NI-1:0] busy, done, rd_clk_en, rd_en, valid, first, last;
  logic [AW-1:0] rd_addr  [NI];
  logic [DW-1:0] rd_data  [NI];
  logic [DW-1:0] pix_data [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    image_bram_reader #(
      .ADDR_DEPTH (AD),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RD_LATENCY (g),
      .FIFO_DEPTH (FD)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .busy_o      (busy[g]),
      .done_o      (done[g]),
      .rd_clk_en_o (rd_clk_en[g]),
      .rd_en_o     (rd_en[g]),
      .rd_addr_o   (rd_addr[g]),
      .rd_data_i   (rd_data[g]),
      .pix_data_o  (pix_data[g]),
      .pix_valid_o (valid[g]),
      .pix_ready_i (ready[g]),
      .pix_first_o (first[g]),
      .pix_last_o  (last[g])
    );

    if (g == 0) begin : g_mem0
      assign rd_data[g] = 16'hA500 + {12'd0, rd_addr[g]};
    end else if (g == 1) begin : g_mem1
      logic [DW-1:0] r_q1;
      always_ff @(posedge clk) begin
        if (rd_en[g]) r_q1 <= 16'hA500 + {12'd0, rd_addr[g]};
      end
      assign rd_data[g] = r_q1;
    end else begin : g_mem2
      logic [DW-1:0] r_q1, r_q2;
      always_ff @(posedge clk) begin
        if (rd_en[g]) r_q1 <= 16'hA500 + {12'd0, rd_addr[g]};
        r_q2 <= r_q1;
      end
      assign rd_data[g] = r_q2;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with reset just released.
  task automatic apply_reset();
    rst   = 1'b1;
    start = 1'b0;
    ready = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy[i], done[i], rd_en[i], rd_clk_en[i], valid[i], first[i], last[i],
           rd_addr[i], pix_data[i]} !== '0) begin
        errors++;
        $display("FAIL reset L=%0d: flags %b addr %0d data %h, required all zero", i,
                 {busy[i], done[i], rd_en[i], rd_clk_en[i], valid[i], first[i], last[i]},
                 rd_addr[i], pix_data[i]);
      end
    end
    repeat (3) next_cycle();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy[i], rd_en[i], valid[i]} !== 3'b000) begin
        errors++;
        $display("FAIL idle_no_start L=%0d: busy/rd_en/valid %b, required 000", i,
                 {busy[i], rd_en[i], valid[i]});
      end
    end
  endtask

  // Cycle-exact frame with ready held high.
  task automatic test_free_run();
    logic [6:0]    exp_f;
    logic [6:0]    got_f;
    int            ea;
    logic [DW-1:0] ed;
    apply_reset();
    for (int c = 0; c < 22; c++) begin
      start = (c == 0);
      for (int i = 0; i < NI; i++) begin
        exp_f = {(c >= 1 && c <= i + 17), (c == i + 18), (c >= 1 && c <= 16),
                 (c >= 1 && c <= 16), (c >= i + 2 && c <= i + 17), (c == i + 2),
                 (c == i + 17)};
        ea    = (c == 0) ? 0 : ((c <= 16) ? c - 1 : 15);
        ed    = (c >= i + 2 && c <= i + 17) ? DW'(32'hA500 + c - i - 2) : '0;
        got_f = {busy[i], done[i], rd_en[i], rd_clk_en[i], valid[i], first[i], last[i]};
        checks++;
        if (got_f !== exp_f || rd_addr[i] !== AW'(ea) || pix_data[i] !== ed) begin
          errors++;
          $display("FAIL free_run L=%0d cycle %0d: busy/done/en/clken/vld/first/last addr data = %b %0d %h, required %b %0d %h",
                   i, c, got_f, rd_addr[i], pix_data[i], exp_f, ea, ed);
        end
      end
      next_cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_stall();
    int nreads   [NI];
    int idx      [NI];
    int ndone    [NI];
    int res_addr [NI];
    int bad      [NI];
    apply_reset();
    ready = '0;
    for (int i = 0; i < NI; i++) begin
      nreads[i] = 0; idx[i] = 0; ndone[i] = 0; res_addr[i] = -1; bad[i] = 0;
    end
    for (int c = 0; c < 12; c++) begin
      start = (c == 0);
      for (int i = 0; i < NI; i++) if (rd_en[i]) nreads[i]++;
      next_cycle();
    end
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (nreads[i] != 4 || rd_en[i] !== 1'b0 || rd_addr[i] !== AW'(4)) begin
        errors++;
        $display("FAIL stall_credit L=%0d: reads %0d rd_en %b addr %0d, required 4 0 4",
                 i, nreads[i], rd_en[i], rd_addr[i]);
      end
      checks++;
      if ({valid[i], first[i], pix_data[i]} !== {2'b11, 16'hA500}) begin
        errors++;
        $display("FAIL stall_head L=%0d: valid/first/data %b%b %h, required 11 a500",
                 i, valid[i], first[i], pix_data[i]);
      end
    end
    ready = '1;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (rd_en[i] && res_addr[i] < 0) res_addr[i] = int'(rd_addr[i]);
        if (done[i]) ndone[i]++;
        if (valid[i]) begin
          if (pix_data[i] !== DW'(32'hA500 + idx[i]) || first[i] !== (idx[i] == 0) ||
              last[i] !== (idx[i] == 15)) bad[i]++;
          idx[i]++;
        end
      end
      next_cycle();
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (res_addr[i] != 4) begin
        errors++;
        $display("FAIL stall_resume_addr L=%0d: first read after release at %0d, required 4",
                 i, res_addr[i]);
      end
      checks++;
      if (idx[i] != 16 || bad[i] != 0 || ndone[i] != 1) begin
        errors++;
        $display("FAIL stall_drain L=%0d: pixels %0d out-of-order %0d dones %0d, required 16 0 1",
                 i, idx[i], bad[i], ndone[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    int npix  [NI];
    int ndone [NI];
    int c;
    apply_reset();
    for (int i = 0; i < NI; i++) begin npix[i] = 0; ndone[i] = 0; end
    for (int k = 0; k < 30; k++) begin
      start = (k == 0 || k == 5 || k == 10);
      for (int i = 0; i < NI; i++) begin
        if (valid[i] && ready[i]) npix[i]++;
        if (done[i]) ndone[i]++;
      end
      next_cycle();
    end
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (npix[i] != 16 || ndone[i] != 1 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL start_while_busy L=%0d: pixels %0d dones %0d busy %b, required 16 1 0",
                 i, npix[i], ndone[i], busy[i]);
      end
    end

    // Start held from the done cycle onward: ignored in the done cycle,
    // accepted in the next one.
    apply_reset();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    c = 0;
    while (done[1] !== 1'b1 && c < 40) begin
      next_cycle();
      c++;
    end
    checks++;
    if (c != 18) begin
      errors++;
      $display("FAIL done_timing L=1: done after %0d further cycles, required 18", c);
    end
    start = 1'b1;
    next_cycle();
    checks++;
    if ({busy[1], rd_en[1]} !== 2'b00) begin
      errors++;
      $display("FAIL start_in_done L=1: busy/rd_en %b, required 00", {busy[1], rd_en[1]});
    end
    next_cycle();
    start = 1'b0;
    checks++;
    if ({busy[1], rd_en[1]} !== 2'b11 || rd_addr[1] !== AW'(0)) begin
      errors++;
      $display("FAIL start_after_done L=1: busy/rd_en %b addr %0d, required 11 0",
               {busy[1], rd_en[1]}, rd_addr[1]);
    end
  endtask

  task automatic test_reset_mid();
    int idx   [NI];
    int bad   [NI];
    int noise [NI];
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      start = (c == 0);
      if (c == 8) rst = 1'b1;
      next_cycle();
    end
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      idx[i] = 0; bad[i] = 0; noise[i] = 0;
      checks++;
      if ({busy[i], done[i], rd_en[i], rd_clk_en[i], valid[i], first[i], last[i],
           rd_addr[i], pix_data[i]} !== '0) begin
        errors++;
        $display("FAIL reset_mid L=%0d: flags %b addr %0d data %h, required all zero", i,
                 {busy[i], done[i], rd_en[i], rd_clk_en[i], valid[i], first[i], last[i]},
                 rd_addr[i], pix_data[i]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NI; i++) if (valid[i] || rd_en[i] || done[i]) noise[i]++;
      next_cycle();
    end
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (valid[i]) begin
          if (pix_data[i] !== DW'(32'hA500 + idx[i]) || first[i] !== (idx[i] == 0) ||
              last[i] !== (idx[i] == 15)) bad[i]++;
          idx[i]++;
        end
      end
      next_cycle();
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (noise[i] != 0 || idx[i] != 16 || bad[i] != 0) begin
        errors++;
        $display("FAIL reset_mid_reframe L=%0d: residual %0d pixels %0d out-of-order %0d, required 0 16 0",
                 i, noise[i], idx[i], bad[i]);
      end
    end
  endtask

  task automatic test_random();
    int          idx    [NI];
    int          ndone  [NI];
    int          issued [NI];
    int          popped [NI];
    logic        stall  [NI];
    logic [17:0] held   [NI];
    logic        all_done;
    apply_reset();
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NI; i++) begin
        idx[i] = 0; ndone[i] = 0; issued[i] = 0; popped[i] = 0; stall[i] = 1'b0;
      end
      start = 1'b1;
      ready = NI'($urandom);
      next_cycle();
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
        ready = NI'($urandom);
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (issued[i] - popped[i] > FD) begin
            errors++;
            $display("FAIL rand_credit L=%0d frame %0d: %0d outstanding, limit %0d",
                     i, f, issued[i] - popped[i], FD);
          end
          if (stall[i]) begin
            checks++;
            if ({valid[i], first[i], last[i], pix_data[i]} !== {1'b1, held[i]}) begin
              errors++;
              $display("FAIL rand_stable L=%0d frame %0d: valid/first/last/data %b %h, required 1 %h",
                       i, f, valid[i], {first[i], last[i], pix_data[i]}, held[i]);
            end
          end
          if (valid[i] && ready[i]) begin
            checks++;
            if (pix_data[i] !== DW'(32'hA500 + idx[i]) || first[i] !== (idx[i] == 0) ||
                last[i] !== (idx[i] == 15)) begin
              errors++;
              $display("FAIL rand_order L=%0d frame %0d: pixel %0d data %h first %b last %b, required %h",
                       i, f, idx[i], pix_data[i], first[i], last[i], 16'hA500 + idx[i]);
            end
            idx[i]++;
            popped[i]++;
          end
          if (rd_en[i]) issued[i]++;
          if (done[i]) ndone[i]++;
          stall[i] = valid[i] & ~ready[i];
          held[i]  = {first[i], last[i], pix_data[i]};
        end
        all_done = 1'b1;
        for (int i = 0; i < NI; i++) if (ndone[i] == 0) all_done = 1'b0;
        next_cycle();
        if (all_done) break;
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (idx[i] != 16 || ndone[i] != 1) begin
          errors++;
          $display("FAIL rand_frame L=%0d frame %0d: pixels %0d dones %0d, required 16 1",
                   i, f, idx[i], ndone[i]);
        end
      end
    end
    ready = '1;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = '1;
    test_reset();
    test_free_run();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
